// File: rtl/scramble_pkg.sv
// Shared types and constants for the scramble move source.
//   state_e      : burst FSM states
//   dir_t/DIR_*  : move encoding (up/down and left/right are inverse pairs: d^1)
//   LFSR_TAPS    : Fibonacci taps 16,14,13,11 as a bit mask on lfsr[15:0]
//   undo_filter  : replaces a candidate that would undo the previous move
package scramble_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef logic [1:0] dir_t;

  localparam dir_t DIR_UP    = 2'd0;
  localparam dir_t DIR_DOWN  = 2'd1;
  localparam dir_t DIR_LEFT  = 2'd2;
  localparam dir_t DIR_RIGHT = 2'd3;

  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  // Inverse of d is d^1; flipping bit 1 moves to the other axis, so the
  // result can never be the inverse of prev_dir.
  function automatic dir_t undo_filter(input dir_t cand, input logic prev_valid,
                                       input dir_t prev_dir);
    if (prev_valid && (cand == (prev_dir ^ 2'b01))) return cand ^ 2'b10;
    return cand;
  endfunction

endpackage

// File: rtl/scramble_move_source_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR.
//   clk    : clock
//   rst_n  : async active-low reset, loads SEED (0 is replaced by 1)
//   lfsr_o : current LFSR state
module lfsr16
  import scramble_pkg::*;
#(
  parameter logic [15:0] SEED = DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] lfsr_o
);

  localparam logic [15:0] INIT = (SEED == 16'h0000) ? 16'h0001 : SEED;

  logic [15:0] lfsr_q, lfsr_d;

  // All-zero is a lock-up state for an XOR LFSR; kick it back to 1.
  always_comb begin
    lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
    if (lfsr_q == 16'h0000) lfsr_d = 16'h0001;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= INIT;
    else        lfsr_q <= lfsr_d;
  end

  assign lfsr_o = lfsr_q;

endmodule

// File: rtl/scramble_move_source.sv
// Scramble responder: on a request while idle, streams MOVE_COUNT pseudo-random
// sliding-puzzle moves over valid/ready, then pulses done for one cycle.
//   rand_req   : level request, sampled only in IDLE
//   abort      : ends the current burst (wins over a same-cycle handshake)
//   move_ready : downstream accepts the presented move
//   move_valid : move_dir is valid
//   move_dir   : 0=up 1=down 2=left 3=right
//   busy       : burst in progress
//   done       : one-cycle pulse after the last accept or after abort
//   remaining  : moves still to be accepted, including the presented one
module scramble_move_source
  import scramble_pkg::*;
#(
  parameter int          MOVE_COUNT = 31,
  parameter logic [15:0] SEED       = DEFAULT_SEED,
  parameter int          CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rand_req,
  input  logic             abort,
  input  logic             move_ready,
  output logic             move_valid,
  output logic [1:0]       move_dir,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] remaining
);

  localparam logic [CNT_W-1:0] MC  = CNT_W'(MOVE_COUNT);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_e           state_q, state_d;
  dir_t             dir_q, dir_d;
  dir_t             prev_dir_q, prev_dir_d;
  logic             prev_valid_q, prev_valid_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [15:0]      lfsr;
  dir_t             cand;

  lfsr16 #(.SEED(SEED)) u_lfsr (
    .clk    (clk),
    .rst_n  (rst_n),
    .lfsr_o (lfsr)
  );

  assign cand = lfsr[1:0];

  always_comb begin
    state_d      = state_q;
    dir_d        = dir_q;
    prev_dir_d   = prev_dir_q;
    prev_valid_d = prev_valid_q;
    rem_d        = rem_q;
    unique case (state_q)
      ST_IDLE: begin
        if (rand_req) begin
          state_d      = ST_SEND;
          prev_valid_d = 1'b0;
          dir_d        = undo_filter(cand, 1'b0, prev_dir_q);
          rem_d        = MC;
        end
      end
      ST_SEND: begin
        if (abort) begin
          rem_d   = '0;
          state_d = ST_DONE;
        end else if (move_ready) begin
          if (rem_q == ONE) begin
            rem_d   = '0;
            state_d = ST_DONE;
          end else begin
            // Next move is filtered against the one just accepted.
            prev_valid_d = 1'b1;
            prev_dir_d   = dir_q;
            dir_d        = undo_filter(cand, 1'b1, dir_q);
            rem_d        = rem_q - ONE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      dir_q        <= DIR_UP;
      prev_dir_q   <= DIR_UP;
      prev_valid_q <= 1'b0;
      rem_q        <= '0;
    end else begin
      state_q      <= state_d;
      dir_q        <= dir_d;
      prev_dir_q   <= prev_dir_d;
      prev_valid_q <= prev_valid_d;
      rem_q        <= rem_d;
    end
  end

  assign move_valid = (state_q == ST_SEND);
  assign busy       = (state_q == ST_SEND);
  assign done       = (state_q == ST_DONE);
  assign move_dir   = dir_q;
  assign remaining  = rem_q;

endmodule

// File: tb/tb_scramble_move_source.sv
module tb_scramble_move_source;

  localparam logic [15:0] SEED = 16'hACE1;

  logic clk = 1'b0;
  logic rst_n = 1'b0, rst_z_n = 1'b0;
  logic rand_req = 1'b0, abort = 1'b0, move_ready = 1'b1;

  logic [1:0]      mv, bz, dn;
  logic [1:0][1:0] md;
  logic [1:0][7:0] rm;
  logic            z_mv, z_bz, z_dn;
  logic [1:0]      z_md;
  logic [7:0]      z_rm;

  int nchk = 0, nerr = 0;
  bit z_done = 1'b0;

  always #5 clk = ~clk;

  scramble_move_source #(.MOVE_COUNT(3), .SEED(SEED), .CNT_W(8)) u_a (
    .clk(clk), .rst_n(rst_n), .rand_req(rand_req), .abort(abort), .move_ready(move_ready),
    .move_valid(mv[0]), .move_dir(md[0]), .busy(bz[0]), .done(dn[0]), .remaining(rm[0]));

  scramble_move_source #(.MOVE_COUNT(31), .SEED(SEED), .CNT_W(8)) u_b (
    .clk(clk), .rst_n(rst_n), .rand_req(rand_req), .abort(abort), .move_ready(move_ready),
    .move_valid(mv[1]), .move_dir(md[1]), .busy(bz[1]), .done(dn[1]), .remaining(rm[1]));

  scramble_move_source #(.MOVE_COUNT(31), .SEED(16'h0000), .CNT_W(8)) u_z (
    .clk(clk), .rst_n(rst_z_n), .rand_req(1'b0), .abort(1'b0), .move_ready(1'b0),
    .move_valid(z_mv), .move_dir(z_md), .busy(z_bz), .done(z_dn), .remaining(z_rm));

  task automatic chk(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic bit [15:0] lfsr_next(input bit [15:0] l);
    if (l == 16'h0) return 16'h0001;
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  // A move may never be the inverse (d^1) of the move accepted just before.
  function automatic bit [1:0] pick(input bit [1:0] c, input bit has_prev, input bit [1:0] prev);
    if (has_prev && c == (prev ^ 2'd1)) return c ^ 2'd2;
    return c;
  endfunction

  int        MC[2] = '{3, 31};
  bit [15:0] m_lfsr = SEED;
  int        mrem[2] = '{0, 0};   // moves left in burst, 0 when not sending
  bit [1:0]  mdir[2] = '{0, 0};
  bit        mdone[2] = '{0, 0};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_lfsr <= SEED;
      for (int i = 0; i < 2; i++) begin
        mrem[i] <= 0; mdir[i] <= 2'd0; mdone[i] <= 1'b0;
      end
    end else begin
      m_lfsr <= lfsr_next(m_lfsr);
      for (int i = 0; i < 2; i++) begin
        if (mdone[i]) mdone[i] <= 1'b0;
        else if (mrem[i] == 0) begin
          if (rand_req) begin
            mrem[i] <= MC[i];
            mdir[i] <= pick(m_lfsr[1:0], 1'b0, 2'd0);
          end
        end else if (abort) begin
          mrem[i] <= 0; mdone[i] <= 1'b1;
        end else if (move_ready) begin
          if (mrem[i] == 1) begin
            mrem[i] <= 0; mdone[i] <= 1'b1;
          end else begin
            mrem[i] <= mrem[i] - 1;
            mdir[i] <= pick(m_lfsr[1:0], 1'b1, mdir[i]);
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("valid[%0d]", i), mv[i], int'(mrem[i] != 0));
      chk($sformatf("busy[%0d]", i), bz[i], int'(mrem[i] != 0));
      chk($sformatf("done[%0d]", i), dn[i], int'(mdone[i]));
      chk($sformatf("remaining[%0d]", i), rm[i], mrem[i]);
      if (mrem[i] != 0) chk($sformatf("dir[%0d]", i), md[i], mdir[i]);
    end
  end

  // Accepted-move tracker: DUT outputs read at the edge are pre-update values.
  int       acc_cnt[2] = '{0, 0};
  bit       have_last[2] = '{0, 0};
  bit [1:0] last_dir[2] = '{0, 0};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) have_last[i] <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (mv[i] && move_ready && !abort) begin
          if (have_last[i]) chk($sformatf("undo_pair[%0d]", i), int'(md[i] == (last_dir[i] ^ 2'd1)), 0);
          last_dir[i]  <= md[i];
          have_last[i] <= 1'b1;
          acc_cnt[i]   <= acc_cnt[i] + 1;
        end else if (!mv[i]) have_last[i] <= 1'b0;
      end
    end
  end

  // ---------------- SEED=0 period watch ----------------
  initial begin
    int period, zeros;
    period = 0; zeros = 0;
    @(posedge rst_z_n);
    chk("seed0_init", u_z.u_lfsr.lfsr_o, 16'h0001);
    for (int c = 1; c <= 70000; c++) begin
      @(posedge clk); #1;
      if (u_z.u_lfsr.lfsr_o == 16'h0) zeros++;
      if (period == 0 && u_z.u_lfsr.lfsr_o == 16'h0001) period = c;
    end
    chk("seed0_zero_seen", zeros, 0);
    chk("seed0_period", period, 65535);
    z_done = 1'b1;
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(negedge clk); #1;
  endtask

  initial begin
    int base, snap_r, snap_d;
    bit finished;
    repeat (3) tick();
    chk("rst_valid", mv[0], 0);
    chk("rst_remaining", rm[1], 0);
    chk("rst_lfsr", u_a.u_lfsr.lfsr_o, 16'hACE1);

    // Burst with ready high; golden moves from ACE1 are 1,3,3.
    base = acc_cnt[0];
    rst_n = 1'b1; rst_z_n = 1'b1; rand_req = 1'b1; move_ready = 1'b1;
    tick(); rand_req = 1'b0;
    chk("c1_valid", mv[0], 1); chk("c1_rem", rm[0], 3); chk("c1_dir", md[0], 1);
    tick();
    chk("c2_rem", rm[0], 2); chk("c2_dir", md[0], 3);
    tick();
    chk("c3_rem", rm[0], 1); chk("c3_dir", md[0], 3);
    tick();
    chk("c4_done", dn[0], 1); chk("c4_busy", bz[0], 0); chk("c4_valid", mv[0], 0);
    chk("c4_accepted", acc_cnt[0] - base, 3);

    // Stall the 31-move burst for 5 cycles, then random ready to completion.
    move_ready = 1'b0;
    snap_d = md[1]; snap_r = rm[1];
    repeat (5) begin
      tick();
      chk("stall_dir", md[1], snap_d); chk("stall_rem", rm[1], snap_r); chk("stall_valid", mv[1], 1);
    end
    finished = 1'b0;
    for (int k = 0; k < 400; k++) begin
      move_ready = 1'($urandom_range(0, 1));
      tick();
      if (!mv[1]) begin finished = 1'b1; break; end
    end
    chk("burst31_finished", finished, 1);
    chk("burst31_accepted", acc_cnt[1], 31);
    repeat (3) tick();

    // Abort together with the handshake of move 5.
    move_ready = 1'b1; base = acc_cnt[1]; rand_req = 1'b1;
    tick(); rand_req = 1'b0;
    repeat (4) tick();
    chk("pre_abort_rem", rm[1], 27);
    abort = 1'b1;
    tick(); abort = 1'b0;
    chk("abort_done", dn[1], 1); chk("abort_rem", rm[1], 0); chk("abort_valid", mv[1], 0);
    chk("abort_accepted", acc_cnt[1] - base, 4);
    tick();
    chk("abort_idle_done", dn[1], 0); chk("abort_idle_busy", bz[1], 0);

    // Random traffic, including requests held across DONE and stray aborts.
    for (int k = 0; k < 1500; k++) begin
      rand_req   = ($urandom_range(0, 3) != 0);
      abort      = ($urandom_range(0, 29) == 0);
      move_ready = ($urandom_range(0, 2) != 0);
      tick();
    end
    rand_req = 1'b0; abort = 1'b0;
    repeat (40) tick();

    // Asynchronous reset in the middle of a burst.
    move_ready = 1'b1; rand_req = 1'b1;
    tick(); rand_req = 1'b0;
    tick(); tick();
    #1 rst_n = 1'b0;
    #1;
    chk("arst_valid", mv[1], 0); chk("arst_busy", bz[1], 0); chk("arst_rem", rm[1], 0);
    chk("arst_dir", md[1], 0); chk("arst_lfsr", u_b.u_lfsr.lfsr_o, 16'hACE1);
    tick();
    chk("arst_no_done", dn[1], 0);
    tick();
    rst_n = 1'b1;
    chk("arst_release_lfsr", u_a.u_lfsr.lfsr_o, 16'hACE1);
    repeat (5) tick();

    for (int k = 0; k < 80000 && !z_done; k++) tick();
    chk("seed0_watch_finished", z_done, 1);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/scramble_move_source.md
Name: scramble_move_source

Overview:
- Responder side of the scramble request from the shuffle/solve state logic.
- When the request line is high while idle, it emits a fixed-length burst of pseudo-random sliding-puzzle moves on a valid/ready stream, then pulses done.
- The move source is a free-running 16-bit LFSR, so entropy comes from the player's button timing.
- It sits between the shuffle/solve controller and the board-update logic.

Parameters:
- MOVE_COUNT, 31, number of moves per scramble burst (1..255).
- SEED, 16'hACE1, LFSR reset value. A value of 0 is replaced by 16'h0001.
- CNT_W, 8, width of the remaining-move counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- rand_req  input  1  scramble request (level); sampled only in IDLE.
- abort  input  1  synchronous abort of the burst in progress.
- move_ready  input  1  downstream accepts move this cycle.
- move_valid  output  1  move_dir holds a valid move.
- move_dir  output  2  0=up, 1=down, 2=left, 3=right.
- busy  output  1  high in SEND.
- done  output  1  one-cycle pulse after the last move is accepted or on abort.
- remaining  output  CNT_W  moves still to be accepted, including the one presented.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; lfsr=SEED (or 1 if SEED=0); move_valid=0; move_dir=0; busy=0; done=0; remaining=0; prev_valid=0; prev_dir=0.
- LFSR:
  - Fibonacci, taps 16,14,13,11; shifts every cycle in every state, including while stalled.
  - feedback = l[15]^l[13]^l[12]^l[10]; next = {l[14:0], feedback}.
  - If lfsr is ever 0, next = 16'h0001.
- Candidate move: cand = lfsr[1:0] (current-cycle value).
- Anti-undo filter:
  - If prev_valid and cand == prev_dir^1, emit cand^2; otherwise emit cand.
  - A move is never the inverse of the previously emitted move.
- States: IDLE, SEND, DONE.
- IDLE:
  - done=0.
  - If rand_req=1: go to SEND; load move_dir=filtered cand; move_valid=1; remaining=MOVE_COUNT; busy=1; prev_valid=0 before filtering.
  - Latency: move_valid rises the cycle after rand_req is sampled.
- SEND:
  - move_dir/move_valid hold stable while move_ready=0.
  - Handshake (valid & ready) with remaining>1: prev_dir=move_dir; prev_valid=1; move_dir=filtered cand (using updated prev); remaining-=1; move_valid stays 1. Back-to-back moves, one per cycle, if ready is held high.
  - Handshake with remaining==1: move_valid=0; remaining=0; busy=0; go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE. rand_req is ignored in DONE.
- abort:
  - abort=1 in SEND wins over a simultaneous handshake: that move is not counted; move_valid=0; remaining=0; go to DONE.
  - abort is ignored in IDLE and DONE.
- Re-request: rand_req held high across DONE starts a new burst on the next IDLE cycle, giving one idle cycle between bursts.
- Reset mid-burst: returns immediately to the reset values above; no done pulse.
- Counter arithmetic is unsigned CNT_W bits and never wraps (guarded by the remaining==1 check).

Decomposition:
- Shared package scramble_pkg holds:
  - state enum (IDLE, SEND, DONE);
  - direction constants DIR_UP=0, DIR_DOWN=1, DIR_LEFT=2, DIR_RIGHT=3;
  - LFSR tap constant;
  - default SEED.
- One sub-module, lfsr16: free-running LFSR with seed parameter, zero-lock guard and async active-low reset. The FSM, counter and filter stay in the top module.

Test Plan:
- Reset, MOVE_COUNT=3, ready=1, rand_req pulse at cycle 0:
  - move_valid high cycles 1-3;
  - remaining shows 3,2,1;
  - done=1 at cycle 4;
  - busy low at cycle 4;
  - exactly 3 moves match the golden LFSR+filter model from SEED=16'hACE1.
- ready=0 for 5 cycles mid-burst: move_dir and remaining are constant, move_valid stays 1; after ready returns, the count completes to MOVE_COUNT with no lost or duplicated move.
- Default MOVE_COUNT=31, random ready: 31 accepted moves; no consecutive pair (d, d^1) ever accepted.
- abort asserted together with a handshake on move 5: that move is not counted, done pulses next cycle, remaining=0, then IDLE.
- rst_n dropped mid-burst: outputs go to reset values the same cycle, asynchronously; no done pulse; lfsr=16'hACE1 after release.
- SEED=0: lfsr starts at 16'h0001 and is never 0 over 70000 cycles; the full period of 65535 is observed.
